// File: rtl/jzjpcc_mmio_uart_tx.sv
// MMIO UART transmitter: toggle-handshake command word, byte FIFO, 8N1 serialiser.
// Define JZJPCC_MMIO_UART_TX_PARITY_EN for 8E1 frames with a capability flag in txStatus[27].
module jzjpcc_mmio_uart_tx #(
  parameter int CLOCKS_PER_BIT  = 434,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] txCommand,
  output logic [31:0] txStatus,
  output logic        txd
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int TW    = $clog2(CLOCKS_PER_BIT);

`ifdef JZJPCC_MMIO_UART_TX_PARITY_EN
  localparam logic PARITY_CAP = 1'b1;
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;
`else
  localparam logic PARITY_CAP = 1'b0;
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_e;
`endif

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ack_q, ack_d;
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          txd_q, txd_d;

  logic full, empty, push, pop, bit_end;
  logic unused_cmd;

  assign unused_cmd = ^txCommand[31:9];

  // Full is judged on the registered count, so a pop edge never frees a slot early.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push    = (txCommand[8] != ack_q) && !full;
  assign pop     = (state_q == S_IDLE) && !empty;
  assign bit_end = (timer_q == TW'(CLOCKS_PER_BIT - 1));

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ack_d     = ack_q;
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    txd_d     = 1'b1;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      ack_d    = ~ack_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    if (state_q == S_IDLE || bit_end) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        txd_d     = 1'b1;
        bit_idx_d = '0;
        if (pop) begin
          shift_d  = mem_q[rd_ptr_q];
          parity_d = ^mem_q[rd_ptr_q];
          state_d  = S_START;
        end
      end
      S_START: begin
        txd_d = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        txd_d = shift_q[0];
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef JZJPCC_MMIO_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef JZJPCC_MMIO_UART_TX_PARITY_EN
      S_PARITY: begin
        txd_d = parity_q;
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        txd_d = 1'b1;
        if (bit_end) state_d = S_IDLE;
      end
      default: begin
        txd_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ack_q     <= 1'b0;
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      txd_q     <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ack_q     <= ack_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      txd_q     <= txd_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= txCommand[7:0];
  end

  assign txd = txd_q;

  assign txStatus = {
    4'b0,
    PARITY_CAP,
    (state_q != S_IDLE),
    empty,
    full,
    8'(count_q),
    7'b0,
    ack_q,
    8'b0
  };

endmodule

// File: tb/tb_jzjpcc_mmio_uart_tx.sv
// Randomised scoreboard bench for jzjpcc_mmio_uart_tx.
// A UART receiver model decodes txd and checks frames against queued bytes.
module tb_jzjpcc_mmio_uart_tx;

  localparam int CPB = 4;
  localparam int DL2 = 2;
`ifdef JZJPCC_MMIO_UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [31:0] EXP_IDLE = 32'h0A000000;
`else
  localparam int NB = 10;
  localparam logic [31:0] EXP_IDLE = 32'h02000000;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] txCommand = 32'h0;
  logic [31:0] txStatus;
  logic        txd;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic tog = 1'b0;
  logic [7:0] exp_q[$];
  int start_cyc[$];

  jzjpcc_mmio_uart_tx #(
    .CLOCKS_PER_BIT(CPB),
    .FIFO_DEPTH_LOG2(DL2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .txCommand(txCommand),
    .txStatus(txStatus),
    .txd(txd)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic sw_push(input logic [7:0] b);
    int n;
    tog = ~tog;
    exp_q.push_back(b);
    txCommand = {23'h0, tog, b};
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (txStatus[8] !== tog && n < 2000);
    if (n >= 2000) chk("push_ack_timeout", {31'h0, txStatus[8]}, {31'h0, tog});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(txStatus[25] === 1'b1 && txStatus[26] === 1'b0) && n < 3000);
    if (n >= 3000) chk("idle_timeout", {31'h0, txStatus[26]}, 32'h0);
    repeat (4) @(negedge clock);
  endtask

  // Receiver model: every bit must hold for exactly CPB samples.
  initial begin : monitor
    logic prev;
    logic [10:0] bits;
    logic ok, abort;
    logic [7:0] e;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      if (!reset && txd === 1'b0 && prev === 1'b1) begin
        start_cyc.push_back(cyc);
        bits = '0;
        ok = 1'b1;
        abort = 1'b0;
        for (int b = 0; b < NB; b++) begin
          for (int s = 0; s < CPB; s++) begin
            if (!(b == 0 && s == 0)) @(negedge clock);
            if (reset) abort = 1'b1;
            if (s == 0) bits[b] = txd;
            else if (txd !== bits[b]) ok = 1'b0;
          end
        end
        if (!abort) begin
          chk("bit_width", {31'h0, ok}, 32'h1);
          chk("stop_bit", {31'h0, bits[NB-1]}, 32'h1);
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", {24'h0, bits[8:1]}, 32'hFFFFFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("frame_data", {24'h0, bits[8:1]}, {24'h0, e});
`ifdef JZJPCC_MMIO_UART_TX_PARITY_EN
            chk("parity_bit", {31'h0, bits[9]}, {31'h0, ^e});
`endif
          end
        end
      end
      prev = txd;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic ok, old;
    int n, k, s0;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    chk("reset_txd", {31'h0, txd}, 32'h1);
    chk("reset_status", txStatus, EXP_IDLE);

    // Single frame with exact latency
    tog = 1'b1;
    exp_q.push_back(8'h55);
    txCommand = 32'h155;
    @(negedge clock);
    chk("ack_after_push", {31'h0, txStatus[8]}, 32'h1);
    chk("count_after_push", {24'h0, txStatus[23:16]}, 32'h1);
    chk("txd_high_n0", {31'h0, txd}, 32'h1);
    @(negedge clock);
    chk("busy_after_pop", {31'h0, txStatus[26]}, 32'h1);
    chk("txd_high_n1", {31'h0, txd}, 32'h1);
    @(negedge clock);
    chk("txd_fall_n2", {31'h0, txd}, 32'h0);
    ok = 1'b1;
    for (int i = 0; i < NB * CPB - 2; i++) begin
      @(negedge clock);
      if (txStatus[26] !== 1'b1) ok = 1'b0;
    end
    chk("busy_in_frame", {31'h0, ok}, 32'h1);
    wait_idle();

    // Fill FIFO while transmitter is mid-frame
    k = start_cyc.size();
    sw_push(8'h3C);
    repeat (2) @(negedge clock);
    sw_push(8'hA1);
    sw_push(8'hA2);
    sw_push(8'hA3);
    sw_push(8'hA4);
    chk("full_count", {24'h0, txStatus[23:16]}, 32'h4);
    chk("full_flag", {31'h0, txStatus[24]}, 32'h1);
    old = tog;
    tog = ~tog;
    exp_q.push_back(8'hA5);
    txCommand = {23'h0, tog, 8'hA5};
    ok = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (txStatus[8] !== old || txStatus[23:16] !== 8'd4) ok = 1'b0;
    end
    chk("fifth_pending", {31'h0, ok}, 32'h1);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (txStatus[23:16] === 8'd4 && n < 200);
    chk("pop_from_full", {24'h0, txStatus[23:16]}, 32'h3);
    chk("no_ack_on_pop_edge", {31'h0, txStatus[8]}, {31'h0, old});
    @(negedge clock);
    chk("fifth_ack", {31'h0, txStatus[8]}, {31'h0, tog});
    chk("fifth_count", {24'h0, txStatus[23:16]}, 32'h4);
    wait_idle();
    chk("burst_frames", start_cyc.size(), k + 6);
    ok = 1'b1;
    if (start_cyc.size() >= k + 6)
      for (int i = 1; i < 6; i++)
        if (start_cyc[k+i] - start_cyc[k+i-1] != NB * CPB + 1) ok = 1'b0;
    chk("one_idle_gap", {31'h0, ok}, 32'h1);

    // Random traffic, including the parity reference bytes
    sw_push(8'h07);
    sw_push(8'h03);
    for (int i = 0; i < 12; i++) begin
      sw_push(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 50)) @(negedge clock);
    end
    wait_idle();
    chk("random_drained", exp_q.size(), 0);

    // Data changes without toggle: no push
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      txCommand = {23'h0, tog, (i < 10) ? 8'h00 : 8'hFF};
      @(negedge clock);
      if (txStatus[23:16] !== 8'd0 || txStatus[8] !== tog || txd !== 1'b1)
        ok = 1'b0;
    end
    chk("no_toggle_no_push", {31'h0, ok}, 32'h1);

    // Reset during data bit 3 with two bytes queued
    k = start_cyc.size();
    sw_push(8'h11);
    sw_push(8'h22);
    sw_push(8'h33);
    n = 0;
    while (start_cyc.size() <= k && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (start_cyc.size() > k) begin
      s0 = start_cyc[k];
      while (cyc < s0 + 4 * CPB + 1) @(negedge clock);
      chk("queued_before_reset", {24'h0, txStatus[23:16]}, 32'h2);
      chk("txd_bit3", {31'h0, txd}, {31'h0, 1'b0});
      #1;
      reset = 1'b1;
      txCommand = 32'h0;
      tog = 1'b0;
      exp_q.delete();
      #1;
      chk("reset_txd_async", {31'h0, txd}, 32'h1);
      chk("reset_status_async", txStatus, EXP_IDLE);
      repeat (3) @(negedge clock);
      reset = 1'b0;
      ok = 1'b1;
      repeat (100) begin
        @(negedge clock);
        if (txd !== 1'b1 || txStatus !== EXP_IDLE) ok = 1'b0;
      end
      chk("no_resume_after_reset", {31'h0, ok}, 32'h1);
    end else begin
      chk("frame_start_timeout", start_cyc.size(), k + 1);
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
